fim_pf_vf_steer: RTL and testbench
==================================

Name: fim_pf_vf_steer

Overview:
- Source-side packet steering adapter that feeds one input port of the PF/VF crossbar switch.
- Takes a single sop/eop packet stream and decodes a destination index from the header beat.
- Drives the one-hot per-destination valid/sop/eop vectors the switch expects, holding the route for the whole packet.
- Drops packets with illegal destinations and counts protocol/drop errors.

Parameters:
- WIDTH, 80, data beat width in bits.
- M, 2, number of switch destinations (width of the valid/sop/eop/ready vectors).
- DEST_LSB, 0, bit offset of the destination field within in_data on the sop beat.
- DEST_W, 1, width of the destination field; DEST_W >= clog2(M).
- CNT_W, 16, width of the drop and error counters.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  WIDTH  upstream packet beat.
- in_sop  input  1  start of packet.
- in_eop  input  1  end of packet.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  adapter can accept a beat.
- out_data  output  WIDTH  beat toward switch input port.
- out_sop  output  M  one-hot sop, set only at the routed destination bit.
- out_eop  output  M  one-hot eop, set only at the routed destination bit.
- out_valid  output  M  one-hot valid per destination.
- out_ready  input  M  per-destination ready from switch.
- drop_cnt  output  CNT_W  saturating count of dropped packets.
- err_cnt  output  CNT_W  saturating count of orphan beats (non-sop beat while idle).
- err_sticky  output  1  set on any drop or orphan; cleared only by rst.

Behaviour:
- Reset: clk/rst only; sync, active-high. During rst and the cycle it is asserted: state=IDLE, skid buffer empty, out_valid=0, out_sop=0, out_eop=0, out_data=0, in_ready=0, drop_cnt=0, err_cnt=0, err_sticky=0. in_ready rises the first cycle after rst deasserts.
- Input accept: beat accepted when in_valid & in_ready.
- in_ready is registered and equals "skid buffer holds fewer than 2 entries". It must never depend combinationally on out_ready.
- Route decode: on an accepted beat with in_sop=1, dest = in_data[DEST_LSB +: DEST_W].
- FSM states:
  - IDLE: accepted sop with dest<M -> beat written to buffer tagged with dest. Go to FWD if !in_eop; stay IDLE if sop&eop.
  - IDLE: accepted sop with dest>=M -> beat discarded, drop_cnt+1, err_sticky=1. Go to DROP if !in_eop, else stay IDLE.
  - IDLE: accepted non-sop beat -> discarded, err_cnt+1, err_sticky=1, stay IDLE.
  - FWD: each accepted beat is written with the latched dest. in_eop -> IDLE. A beat with in_sop=1 in FWD is forwarded unchanged, with no re-route and no error.
  - DROP: accepted beats are discarded; in_eop -> IDLE.
- Skid buffer: 2-entry FIFO of {data, sop, eop, dest}. Head drives outputs:
  - out_valid[d] = head_valid & (head.dest==d).
  - out_sop and out_eop are masked the same way.
  - out_data = head.data; out_data is 0 when the buffer is empty.
- Pop when out_valid[head.dest] & out_ready[head.dest]. out_ready bits for other destinations are ignored.
- Latency: an accepted beat appears on out_* the next cycle if the buffer was empty. Full throughput is 1 beat/cycle with out_ready held high.
- Simultaneous push and pop: allowed; occupancy is unchanged. With the buffer full, push is impossible because in_ready=0.
- Output stability: while out_valid is asserted and not accepted, out_data, out_sop, out_eop and out_valid must hold stable.
- Counters: saturate at all-ones, never wrap.
- Reset mid-packet: buffer flushed and FSM to IDLE; the partial packet is lost. The switch is reset on the same rst.

Optional Feature:
- Macro FIM_PF_VF_STEER_STATS_EN.
- When defined: adds output pkt_cnt [M-1:0][31:0]. pkt_cnt[d] increments when an eop beat pops toward destination d. It wraps modulo 2^32 and resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release: rst high 3 cycles then low -> in_ready=0 during reset, 1 the next cycle; out_valid=0; counters 0.
- 4-beat packet, M=2, dest field=1, out_ready=2'b11 -> out_valid=2'b10 on 4 consecutive cycles starting 1 cycle after first accept; out_sop=2'b10 on beat 0 only; out_eop=2'b10 on beat 3 only.
- Backpressure: out_ready[1]=0 for 5 cycles during a dest=1 packet, out_ready[0]=1 -> in_ready drops after 2 buffered beats; head beat held stable; no beat lost or duplicated after release.
- Illegal dest: M=3, DEST_W=2, dest=3, 3-beat packet -> no out_valid; drop_cnt=1; err_sticky=1; next legal single-beat packet (sop&eop, dest=2) -> out_valid=3'b100 with sop and eop set.
- Orphan beat: in_valid with in_sop=0 while IDLE -> discarded, err_cnt=1. Counter saturation: force 2^CNT_W+2 orphans -> err_cnt stays 0xFFFF.
- Reset mid-packet: rst asserted after beat 2 of a 4-beat packet -> out_valid=0 next cycle; a fresh sop to dest 0 afterwards routes correctly. With FIM_PF_VF_STEER_STATS_EN, pkt_cnt[0]=1 after it completes.

Source files
------------

// File: rtl/fim_pf_vf_steer.sv
// Source-side steering adapter: decodes a destination from the sop beat and drives one-hot
// valid/sop/eop toward the PF/VF switch through a 2-entry skid buffer.
// Optional per-destination packet counters are enabled by FIM_PF_VF_STEER_STATS_EN.
module fim_pf_vf_steer #(
  parameter int unsigned WIDTH    = 80,
  parameter int unsigned M        = 2,
  parameter int unsigned DEST_LSB = 0,
  parameter int unsigned DEST_W   = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [M-1:0]            out_sop,
  output logic [M-1:0]            out_eop,
  output logic [M-1:0]            out_valid,
  input  logic [M-1:0]            out_ready,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic                    err_sticky
`ifdef FIM_PF_VF_STEER_STATS_EN
  ,
  output logic [M-1:0][31:0]      pkt_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              r_state, w_state_nxt;
  logic [DEST_W-1:0]   r_dest, w_in_dest, w_push_dest;
  logic                w_acc, w_is_legal, w_push, w_drop, w_orphan;

  logic [WIDTH-1:0]    r_buf_data [2];
  logic [DEST_W-1:0]   r_buf_dest [2];
  logic [1:0]          r_buf_sop, r_buf_eop;
  logic                r_wr_ptr, r_rd_ptr;
  logic [1:0]          r_count, w_count_nxt;
  logic                r_in_ready, w_head_valid, w_pop;
  logic [CNT_W-1:0]    r_drop_cnt, r_err_cnt;
  logic                r_err_sticky;

  assign w_acc      = in_valid & r_in_ready;
  assign w_in_dest  = in_data[DEST_LSB +: DEST_W];
  assign w_is_legal = 32'(w_in_dest) < M;

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      case (r_state)
        StIdle:        if (in_sop && !in_eop) w_state_nxt = w_is_legal ? StFwd : StDrop;
        StFwd, StDrop: if (in_eop) w_state_nxt = StIdle;
        default:       w_state_nxt = StIdle;
      endcase
    end
  end

  always_comb begin
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_orphan    = 1'b0;
    w_push_dest = r_dest;
    if (w_acc) begin
      case (r_state)
        StIdle: begin
          if (!in_sop)         w_orphan = 1'b1;
          else if (w_is_legal) begin
            w_push      = 1'b1;
            w_push_dest = w_in_dest;
          end else             w_drop = 1'b1;
        end
        StFwd:   w_push = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                           r_dest <= '0;
    else if (w_acc && r_state == StIdle && in_sop && w_is_legal) r_dest <= w_in_dest;
  end

  // Head of the skid buffer drives the switch; only the routed bit is ever set.
  assign w_head_valid = r_count != 2'd0;
  assign out_data     = w_head_valid ? r_buf_data[r_rd_ptr] : '0;

  always_comb begin
    out_valid = '0;
    out_sop   = '0;
    out_eop   = '0;
    for (int unsigned d = 0; d < M; d++) begin
      if (w_head_valid && 32'(r_buf_dest[r_rd_ptr]) == d) begin
        out_valid[d] = 1'b1;
        out_sop[d]   = r_buf_sop[r_rd_ptr];
        out_eop[d]   = r_buf_eop[r_rd_ptr];
      end
    end
  end

  assign w_pop       = |(out_valid & out_ready);
  assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= w_count_nxt != 2'd2;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_data[r_wr_ptr] <= in_data;
      r_buf_dest[r_wr_ptr] <= w_push_dest;
      r_buf_sop[r_wr_ptr]  <= in_sop;
      r_buf_eop[r_wr_ptr]  <= in_eop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt   <= '0;
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_drop && r_drop_cnt != '1)  r_drop_cnt <= r_drop_cnt + CntOne;
      if (w_orphan && r_err_cnt != '1) r_err_cnt  <= r_err_cnt + CntOne;
      if (w_drop || w_orphan)          r_err_sticky <= 1'b1;
    end
  end

  assign in_ready   = r_in_ready;
  assign drop_cnt   = r_drop_cnt;
  assign err_cnt    = r_err_cnt;
  assign err_sticky = r_err_sticky;

`ifdef FIM_PF_VF_STEER_STATS_EN
  logic [M-1:0][31:0] r_pkt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt <= '0;
    end else begin
      for (int unsigned d = 0; d < M; d++) begin
        if (w_pop && out_eop[d]) r_pkt_cnt[d] <= r_pkt_cnt[d] + 32'd1;
      end
    end
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_fim_pf_vf_steer.sv
// Self-checking bench for fim_pf_vf_steer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized packets and backpressure.
module tb_fim_pf_vf_steer;
  localparam int unsigned W  = 80;
  localparam int unsigned M  = 3;
  localparam int unsigned DW = 2;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic [M-1:0]  out_sop, out_eop, out_valid;
  logic [M-1:0]  out_ready = '1;
  logic [CW-1:0] drop_cnt, err_cnt;
  logic          err_sticky;
`ifdef FIM_PF_VF_STEER_STATS_EN
  logic [M-1:0][31:0] pkt_cnt;
`endif

  fim_pf_vf_steer #(.WIDTH(W), .M(M), .DEST_LSB(0), .DEST_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt),
    .err_cnt(err_cnt), .err_sticky(err_sticky)
`ifdef FIM_PF_VF_STEER_STATS_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         sop;
    logic         eop;
    int           dest;
  } beat_t;

  // Reference model: what sits in the adapter and what it must report.
  beat_t         q[$];
  int            m_mode = 0;  // 0 idle, 1 forwarding, 2 dropping
  int            m_dest = 0;
  logic          m_rdy = 1'b0;
  logic [CW-1:0] m_drop = '0, m_err = '0;
  logic          m_sticky = 1'b0;
  logic [31:0]   m_pkt [M];

  int n_chk = 0, n_pass = 0;
  bit rnd_on = 1'b0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [W-1:0] mkdata(input int d);
    logic [W-1:0] v;
    v[31:0]  = $urandom;
    v[63:32] = $urandom;
    v[79:64] = 16'($urandom);
    v[1:0]   = 2'(d);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_mode = 0; m_rdy = 1'b0; m_drop = '0; m_err = '0; m_sticky = 1'b0;
      for (int d = 0; d < M; d++) m_pkt[d] = '0;
    end else begin
      bit acc;
      int d;
      acc = in_valid && m_rdy;
      if (q.size() > 0 && out_ready[q[0].dest]) begin
        if (q[0].eop) m_pkt[q[0].dest] = m_pkt[q[0].dest] + 32'd1;
        void'(q.pop_front());
      end
      if (acc) begin
        if (m_mode == 0) begin
          if (!in_sop) begin
            if (m_err != '1) m_err = m_err + 1'b1;
            m_sticky = 1'b1;
          end else begin
            d = int'(in_data[1:0]);
            if (d < M) begin
              q.push_back('{in_data, in_sop, in_eop, d});
              m_dest = d;
              m_mode = in_eop ? 0 : 1;
            end else begin
              if (m_drop != '1) m_drop = m_drop + 1'b1;
              m_sticky = 1'b1;
              m_mode = in_eop ? 0 : 2;
            end
          end
        end else begin
          if (m_mode == 1) q.push_back('{in_data, in_sop, in_eop, m_dest});
          if (in_eop) m_mode = 0;
        end
      end
      m_rdy = q.size() < 2;
    end
  end

  always @(negedge clk) begin
    logic [M-1:0] ev, es, ee;
    logic [W-1:0] ed;
    ev = '0; es = '0; ee = '0; ed = '0;
    if (q.size() > 0) begin
      ev[q[0].dest] = 1'b1;
      es[q[0].dest] = q[0].sop;
      ee[q[0].dest] = q[0].eop;
      ed            = q[0].data;
    end
    check("out_valid", out_valid, ev);
    check("out_sop", out_sop, es);
    check("out_eop", out_eop, ee);
    check("out_data", out_data, ed);
    check("in_ready", in_ready, m_rdy);
    check("drop_cnt", drop_cnt, m_drop);
    check("err_cnt", err_cnt, m_err);
    check("err_sticky", err_sticky, m_sticky);
`ifdef FIM_PF_VF_STEER_STATS_EN
    for (int d = 0; d < M; d++) check("pkt_cnt", pkt_cnt[d], m_pkt[d]);
`endif
  end

  always @(negedge clk) begin
    if (rnd_on) out_ready = 3'($urandom);
  end

  // Called at a negedge; returns at the negedge right after the beat was accepted.
  task automatic send(input logic [W-1:0] d, input logic s, input logic e);
    int guard;
    guard = 0;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready stuck at %0b, required 1 at %0t", in_ready, $time);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] d0;
    int dst, len;
    logic s;

    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_valid", out_valid, 3'b000);
    check("rel_cnt", {drop_cnt, err_cnt}, 32'd0);

    // 4-beat packet to dest 1, full throughput
    for (int i = 0; i < 4; i++) begin
      send(mkdata(1), i == 0, i == 3);
      check("pkt4_valid", out_valid, 3'b010);
      check("pkt4_sop", out_sop, (i == 0) ? 3'b010 : 3'b000);
      check("pkt4_eop", out_eop, (i == 3) ? 3'b010 : 3'b000);
    end
    @(negedge clk);
    check("pkt4_idle", out_valid, 3'b000);

    // Backpressure on dest 1 only
    out_ready = 3'b101;
    d0 = mkdata(1);
    send(d0, 1'b1, 1'b0);
    send(mkdata(1), 1'b0, 1'b0);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_head", out_data, d0);
    repeat (3) @(negedge clk);
    check("bp_hold_data", out_data, d0);
    check("bp_hold_valid", out_valid, 3'b010);
    check("bp_hold_sop", out_sop, 3'b010);
    out_ready = 3'b111;
    send(mkdata(1), 1'b0, 1'b0);
    send(mkdata(1), 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // Illegal destination 3, then a legal single-beat packet to dest 2
    send(mkdata(3), 1'b1, 1'b0);
    check("drop_valid", out_valid, 3'b000);
    send(mkdata(2), 1'b0, 1'b0);
    send(mkdata(1), 1'b0, 1'b1);
    check("drop_cnt_lit", drop_cnt, 16'd1);
    check("drop_sticky", err_sticky, 1'b1);
    send(mkdata(2), 1'b1, 1'b1);
    check("single_valid", out_valid, 3'b100);
    check("single_sop", out_sop, 3'b100);
    check("single_eop", out_eop, 3'b100);
    @(negedge clk);

    // Orphans and counter saturation
    send(mkdata(0), 1'b0, 1'b0);
    check("orphan_err", err_cnt, 16'd1);
    check("orphan_valid", out_valid, 3'b000);
    for (int i = 0; i < 65538; i++) send(mkdata(0), 1'b0, 1'b0);
    @(negedge clk);
    check("err_sat", err_cnt, 16'hFFFF);

    // Randomized packets with random per-destination backpressure
    rnd_on = 1'b1;
    for (int p = 0; p < 300; p++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) send(mkdata(0), 1'b0, 1'b0);
      dst = $urandom_range(0, 3);
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        s = (b == 0) || ($urandom_range(0, 7) == 0);
        send(mkdata((b == 0) ? dst : $urandom_range(0, 3)), s, b == len - 1);
      end
    end
    rnd_on = 1'b0;
    @(negedge clk);
    out_ready = 3'b111;
    repeat (4) @(negedge clk);

    // Reset in the middle of a packet
    send(mkdata(1), 1'b1, 1'b0);
    send(mkdata(1), 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 3'b000);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_cnt", {drop_cnt, err_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send(mkdata(0), 1'b1, 1'b1);
    check("post_rst_valid", out_valid, 3'b001);
    check("post_rst_sop", out_sop, 3'b001);
    @(negedge clk);
    check("post_rst_empty", out_valid, 3'b000);
`ifdef FIM_PF_VF_STEER_STATS_EN
    check("post_rst_pkt0", pkt_cnt[0], 32'd1);
`endif
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
